// File: rtl/trap_ctrl_if.sv
// CSR write-port bundle shared by the WB stage, the trap sequencer and the CSR file.
// The WB side raises a write request; the sequencer forwards it or substitutes its own writes.
interface trap_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_waddr_i;
    logic [DATA_WIDTH-1:0] wb_wdata_i;
    logic                  csr_we_o;
    logic [ADDR_WIDTH-1:0] csr_waddr_o;
    logic [DATA_WIDTH-1:0] csr_wdata_o;

    // Pipeline / CSR-file side: issues WB requests, observes the arbitrated port.
    modport master (
        output wb_we_i, wb_waddr_i, wb_wdata_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o
    );

    // Trap sequencer side: accepts WB requests, drives the arbitrated port.
    modport slave (
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects exceptions, mret and enabled interrupts on the
// EXE instruction, walks the single CSR write port through the trap-entry/return updates,
// then pulses a PC redirect. Outside a sequence the WB CSR write passes straight through.
module trap_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inst_valid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  illegal_i,
    input  logic                  mret_i,
    input  logic                  meip_i,
    input  logic                  mtip_i,
    input  logic                  msip_i,
    input  logic [DATA_WIDTH-1:0] mstatus_i,
    input  logic [DATA_WIDTH-1:0] mie_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    trap_ctrl_if.slave            csr_bus,
    output logic                  flush_o,
    output logic                  busy_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MEPC,
        S_WR_MCAUSE,
        S_WR_MSTATUS,
        S_MRET_MSTATUS,
        S_REDIRECT
    } state_t;

    localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC   = CSR_ADDR_WIDTH'(12'h305);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

    localparam logic [DATA_WIDTH-1:0] C_IRQ_BIT = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] C_ILLEGAL = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] C_EBREAK  = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] C_ECALL   = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] C_MEI     = C_IRQ_BIT | DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] C_MSI     = C_IRQ_BIT | DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] C_MTI     = C_IRQ_BIT | DATA_WIDTH'(7);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_cause;
    logic [DATA_WIDTH-1:0]   r_mstatus;   // already-updated mstatus value to write
    logic [DATA_WIDTH-1:0]   r_target;    // redirect target resolved at detect

    logic [DATA_WIDTH-1:0]   w_eff_mstatus;
    logic [DATA_WIDTH-1:0]   w_eff_mtvec;
    logic [DATA_WIDTH-1:0]   w_eff_mepc;
    logic                    w_exc;
    logic                    w_irq_ext;
    logic                    w_irq_sw;
    logic                    w_irq_tm;
    logic                    w_take_irq;
    logic                    w_detect_trap;
    logic                    w_detect_mret;
    logic [DATA_WIDTH-1:0]   w_cause;
    logic [DATA_WIDTH-1:0]   w_trap_ms;
    logic [DATA_WIDTH-1:0]   w_mret_ms;
    logic [DATA_WIDTH-1:0]   w_base;
    logic [DATA_WIDTH-1:0]   w_vec_off;
    logic [DATA_WIDTH-1:0]   w_trap_target;
    logic                    w_we;
    logic [CSR_ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_flush;
    logic                    w_busy;
    logic                    w_redirect;
    logic                    w_unused;

    // A WB write in the detect cycle belongs to an older instruction, so its value wins.
    assign w_eff_mstatus = (csr_bus.wb_we_i && csr_bus.wb_waddr_i == A_MSTATUS) ? csr_bus.wb_wdata_i : mstatus_i;
    assign w_eff_mtvec   = (csr_bus.wb_we_i && csr_bus.wb_waddr_i == A_MTVEC)   ? csr_bus.wb_wdata_i : mtvec_i;
    assign w_eff_mepc    = (csr_bus.wb_we_i && csr_bus.wb_waddr_i == A_MEPC)    ? csr_bus.wb_wdata_i : mepc_i;

    assign w_exc      = illegal_i | ebreak_i | ecall_i;
    assign w_irq_ext  = meip_i & mie_i[11];
    assign w_irq_sw   = msip_i & mie_i[3];
    assign w_irq_tm   = mtip_i & mie_i[7];
    assign w_take_irq = w_eff_mstatus[3] & (w_irq_ext | w_irq_sw | w_irq_tm);

    assign w_detect_trap = inst_valid_i & (w_exc | (~mret_i & w_take_irq));
    assign w_detect_mret = inst_valid_i & ~w_exc & mret_i;

    // Cause selection in fixed priority: exceptions before interrupts, MEI > MSI > MTI.
    always_comb begin
        w_cause = C_MTI;
        if (illegal_i)      w_cause = C_ILLEGAL;
        else if (ebreak_i)  w_cause = C_EBREAK;
        else if (ecall_i)   w_cause = C_ECALL;
        else if (w_irq_ext) w_cause = C_MEI;
        else if (w_irq_sw)  w_cause = C_MSI;
    end

    // Trap-entry and trap-return mstatus images, computed from the effective mstatus.
    always_comb begin
        w_trap_ms        = w_eff_mstatus;
        w_trap_ms[7]     = w_eff_mstatus[3];
        w_trap_ms[3]     = 1'b0;
        w_trap_ms[12:11] = 2'b11;
        w_mret_ms        = w_eff_mstatus;
        w_mret_ms[3]     = w_eff_mstatus[7];
        w_mret_ms[7]     = 1'b1;
        w_mret_ms[12:11] = 2'b11;
    end

    // Vectored mode only applies to interrupts; modes 2/3 fall back to direct.
    assign w_base        = {w_eff_mtvec[DATA_WIDTH-1:2], 2'b00};
    assign w_vec_off     = {w_cause[DATA_WIDTH-3:0], 2'b00};
    assign w_trap_target = (~w_exc && w_eff_mtvec[1:0] == 2'b01) ? (w_base + w_vec_off) : w_base;

    // State register; async reset abandons any sequence in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Capture everything the sequence needs at the detect cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc      <= '0;
            r_cause   <= '0;
            r_mstatus <= '0;
            r_target  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_detect_trap) begin
                r_pc      <= pc_i;
                r_cause   <= w_cause;
                r_mstatus <= w_trap_ms;
                r_target  <= w_trap_target;
            end else if (w_detect_mret) begin
                r_mstatus <= w_mret_ms;
                r_target  <= {w_eff_mepc[DATA_WIDTH-1:2], 2'b00};
            end
        end
    end

    // Next state and write-port ownership: WB in IDLE, the sequencer everywhere else.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = csr_bus.wb_waddr_i;
        w_wdata      = csr_bus.wb_wdata_i;
        w_flush      = 1'b0;
        w_busy       = 1'b1;
        w_redirect   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_we    = csr_bus.wb_we_i;
                w_flush = w_detect_trap | w_detect_mret;
                if (w_detect_trap)      w_state_next = S_WR_MEPC;
                else if (w_detect_mret) w_state_next = S_MRET_MSTATUS;
            end
            S_WR_MEPC: begin
                w_we = 1'b1; w_waddr = A_MEPC; w_wdata = r_pc;
                w_state_next = S_WR_MCAUSE;
            end
            S_WR_MCAUSE: begin
                w_we = 1'b1; w_waddr = A_MCAUSE; w_wdata = r_cause;
                w_state_next = S_WR_MSTATUS;
            end
            S_WR_MSTATUS, S_MRET_MSTATUS: begin
                w_we = 1'b1; w_waddr = A_MSTATUS; w_wdata = r_mstatus;
                w_state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_redirect   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Combinational paths out of IDLE are gated so reset forces them quiet.
    assign csr_bus.csr_we_o    = rst_ni & w_we;
    assign csr_bus.csr_waddr_o = w_waddr;
    assign csr_bus.csr_wdata_o = w_wdata;
    assign flush_o             = rst_ni & w_flush;
    assign busy_o              = w_busy;
    assign redirect_o          = w_redirect;
    assign redirect_pc_o       = w_redirect ? r_target : '0;

    assign w_unused = ^{mie_i[DATA_WIDTH-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                        w_eff_mepc[1:0], w_cause[DATA_WIDTH-1:DATA_WIDTH-2]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of single-instruction detect vectors, hand-written sequences
// for the multi-cycle cases, and a randomized run against a transaction-level model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 0, ecall = 0, ebreak = 0, illegal = 0, mret = 0;
    logic        meip = 0, mtip = 0, msip = 0;
    logic [31:0] pc = 0, mstatus = 0, mie = 0, mtvec = 0, mepc = 0;
    logic        wb_we = 0;
    logic [11:0] wb_waddr = 0;
    logic [31:0] wb_wdata = 0;
    logic        flush, busy, redirect;
    logic [31:0] redirect_pc;

    trap_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();
    assign bus.wb_we_i    = wb_we;
    assign bus.wb_waddr_i = wb_waddr;
    assign bus.wb_wdata_i = wb_wdata;

    trap_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .inst_valid_i(valid), .pc_i(pc),
        .ecall_i(ecall), .ebreak_i(ebreak), .illegal_i(illegal), .mret_i(mret),
        .meip_i(meip), .mtip_i(mtip), .msip_i(msip),
        .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
        .csr_bus(bus), .flush_o(flush), .busy_o(busy), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected behaviour of one post-detect cycle.
    typedef struct {
        logic        busy;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;
    exp_t q[$];

    logic        obs_flush, obs_busy, obs_we, obs_redir;
    logic [11:0] obs_addr;
    logic [31:0] obs_data, obs_rpc, last_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: decides from the architectural rules what the next few cycles do.
    task automatic model_detect(output bit fl);
        logic [31:0] ms, tv, ep, cause, nms, tgt;
        bit trap, is_int, is_mret;
        ms = (wb_we && wb_waddr == 12'h300) ? wb_wdata : mstatus;
        tv = (wb_we && wb_waddr == 12'h305) ? wb_wdata : mtvec;
        ep = (wb_we && wb_waddr == 12'h341) ? wb_wdata : mepc;
        trap = 0; is_int = 0; is_mret = 0; cause = 0;
        if (valid) begin
            if (illegal)     begin trap = 1; cause = 2;  end
            else if (ebreak) begin trap = 1; cause = 3;  end
            else if (ecall)  begin trap = 1; cause = 11; end
            else if (mret)   is_mret = 1;
            else if (ms[3]) begin
                if (meip && mie[11])     begin trap = 1; is_int = 1; cause = 32'h8000000B; end
                else if (msip && mie[3]) begin trap = 1; is_int = 1; cause = 32'h80000003; end
                else if (mtip && mie[7]) begin trap = 1; is_int = 1; cause = 32'h80000007; end
            end
        end
        fl = trap | is_mret;
        if (trap) begin
            nms = (ms & ~32'h00001888) | 32'h00001800 | (ms[3] ? 32'h80 : 32'h0);
            tgt = tv & ~32'h3;
            if (is_int && tv[1:0] == 2'd1) tgt = tgt + 4 * (cause & 32'h7FFFFFFF);
            q.push_back('{1'b1, 1'b1, 12'h341, pc, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b1, 12'h300, nms, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b0, 12'h000, 32'h0, 1'b1, tgt});
        end else if (is_mret) begin
            nms = (ms & ~32'h00001888) | 32'h00001880 | (ms[7] ? 32'h8 : 32'h0);
            q.push_back('{1'b1, 1'b1, 12'h300, nms, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b0, 12'h000, 32'h0, 1'b1, ep & ~32'h3});
        end
    endtask

    // One clock: sample on the falling edge, check against the model, advance past the rising edge.
    task automatic step();
        exp_t e;
        bit   efl, was_busy;
        @(negedge clk);
        obs_flush = flush; obs_busy = busy; obs_we = bus.csr_we_o; obs_addr = bus.csr_waddr_o;
        obs_data = bus.csr_wdata_o; obs_redir = redirect; obs_rpc = redirect_pc;
        if (obs_we && obs_busy && obs_addr == 12'h342) last_cause = obs_data;
        if (!rst_n) begin
            chk("rst_we", obs_we, 0); chk("rst_flush", obs_flush, 0); chk("rst_busy", obs_busy, 0);
            chk("rst_redir", obs_redir, 0); chk("rst_rpc", obs_rpc, 0);
            q.delete();
        end else begin
            was_busy = q.size() > 0;
            efl = 0;
            if (was_busy) e = q[0];
            else begin
                e = '{1'b0, wb_we, wb_waddr, wb_wdata, 1'b0, 32'h0};
                model_detect(efl);
            end
            chk("m_busy", obs_busy, e.busy);
            chk("m_we", obs_we, e.we);
            if (e.we) begin chk("m_addr", obs_addr, e.addr); chk("m_data", obs_data, e.data); end
            chk("m_redir", obs_redir, e.redir);
            if (e.redir) chk("m_rpc", obs_rpc, e.rpc);
            chk("m_flush", obs_flush, efl);
            if (was_busy) void'(q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_flags();
        valid = 0; ecall = 0; ebreak = 0; illegal = 0; mret = 0;
        meip = 0; mtip = 0; msip = 0; wb_we = 0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 8 && q.size() > 0; k++) step();
        step();
        chk({nm, "_idle"}, obs_busy, 0);
    endtask

    task automatic expect_w(input string nm, input logic [11:0] a, input logic [31:0] d);
        step();
        chk({nm, "_we"}, obs_we, 1); chk({nm, "_addr"}, obs_addr, a);
        chk({nm, "_data"}, obs_data, d); chk({nm, "_busy"}, obs_busy, 1);
    endtask

    task automatic expect_redir(input string nm, input logic [31:0] t);
        step();
        chk({nm, "_redir"}, obs_redir, 1); chk({nm, "_rpc"}, obs_rpc, t);
        chk({nm, "_busy"}, obs_busy, 1); chk({nm, "_we"}, obs_we, 0);
    endtask

    typedef struct {
        logic        v, ec, eb, il, mr, ei, ti, si;
        logic [31:0] ms, ie;
        logic        wwe;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        xfl;
        logic [31:0] xcause;
    } vec_t;
    vec_t vt[12];

    initial begin
        //        v  ec eb il mr ei ti si  mstatus  mie      wwe wa       wd     flush cause
        vt[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h888, 0, 12'h000, 32'h0, 0, 32'h0};
        vt[1]  = '{1, 1, 1, 1, 0, 0, 0, 0, 32'h8, 32'h888, 0, 12'h000, 32'h0, 1, 32'd2};
        vt[2]  = '{1, 1, 1, 0, 0, 1, 0, 0, 32'h8, 32'h888, 0, 12'h000, 32'h0, 1, 32'd3};
        vt[3]  = '{1, 1, 0, 0, 1, 0, 0, 0, 32'h8, 32'h888, 0, 12'h000, 32'h0, 1, 32'd11};
        vt[4]  = '{1, 0, 0, 0, 1, 1, 0, 0, 32'h8, 32'h888, 0, 12'h000, 32'h0, 1, 32'h0};
        vt[5]  = '{1, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h888, 0, 12'h000, 32'h0, 0, 32'h0};
        vt[6]  = '{1, 0, 0, 0, 0, 0, 1, 1, 32'h8, 32'h888, 0, 12'h000, 32'h0, 1, 32'h80000003};
        vt[7]  = '{1, 0, 0, 0, 0, 1, 1, 0, 32'h8, 32'h080, 0, 12'h000, 32'h0, 1, 32'h80000007};
        vt[8]  = '{1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h888, 1, 12'h300, 32'h8, 1, 32'h80000007};
        vt[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h000, 0, 12'h000, 32'h0, 1, 32'd11};
        vt[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 32'h8, 32'h888, 1, 12'h300, 32'h0, 0, 32'h0};
        vt[11] = '{1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h880, 0, 12'h000, 32'h0, 0, 32'h0};

        // Reset state, including WB request masked while in reset.
        wb_we = 1; wb_waddr = 12'h300; wb_wdata = 32'h1234;
        #3;
        chk("por_we", bus.csr_we_o, 0); chk("por_busy", busy, 0);
        chk("por_flush", flush, 0); chk("por_redir", redirect, 0); chk("por_rpc", redirect_pc, 0);
        step();
        wb_we = 0;
        rst_n = 1;
        step();

        // Table-driven detect vectors.
        for (int i = 0; i < 12; i++) begin
            valid = vt[i].v; ecall = vt[i].ec; ebreak = vt[i].eb; illegal = vt[i].il; mret = vt[i].mr;
            meip = vt[i].ei; mtip = vt[i].ti; msip = vt[i].si; mstatus = vt[i].ms; mie = vt[i].ie;
            wb_we = vt[i].wwe; wb_waddr = vt[i].wa; wb_wdata = vt[i].wd;
            pc = 32'h1000 + 4 * i; mtvec = 32'h201; mepc = 32'h2000;
            last_cause = 0;
            step();
            chk($sformatf("vec%0d_flush", i), obs_flush, vt[i].xfl);
            clear_flags();
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_cause", i), last_cause, vt[i].xcause);
        end

        // ecall, direct mtvec.
        pc = 32'h100; mtvec = 32'h200; mstatus = 32'h8; mie = 0; valid = 1; ecall = 1;
        step();
        chk("ecall_flush", obs_flush, 1); chk("ecall_T_busy", obs_busy, 0);
        clear_flags();
        expect_w("ecall_mepc", 12'h341, 32'h100);
        expect_w("ecall_mcause", 12'h342, 32'd11);
        expect_w("ecall_mstatus", 12'h300, 32'h1880);
        expect_redir("ecall", 32'h200);
        step(); chk("ecall_after_busy", obs_busy, 0);

        // Timer interrupt, vectored mtvec.
        pc = 32'h40; mtvec = 32'h201; mstatus = 32'h8; mie = 32'h80; valid = 1; mtip = 1;
        step(); chk("mti_flush", obs_flush, 1);
        clear_flags();
        expect_w("mti_mepc", 12'h341, 32'h40);
        expect_w("mti_mcause", 12'h342, 32'h80000007);
        expect_w("mti_mstatus", 12'h300, 32'h1880);
        expect_redir("mti", 32'h21C);
        step();

        // MEI+MTI masked by MIE=0, then MEI wins, MTI taken afterwards.
        mstatus = 32'h0; mie = 32'h880; mtvec = 32'h300; pc = 32'h80; valid = 1; meip = 1; mtip = 1;
        step(); chk("masked_flush", obs_flush, 0);
        step(); chk("masked_busy", obs_busy, 0);
        mstatus = 32'h8;
        step(); chk("mei_flush", obs_flush, 1);
        meip = 0;
        expect_w("mei_mepc", 12'h341, 32'h80);
        expect_w("mei_mcause", 12'h342, 32'h8000000B);
        expect_w("mei_mstatus", 12'h300, 32'h1880);
        expect_redir("mei", 32'h300);
        last_cause = 0;
        step(); chk("mti_pend_flush", obs_flush, 1);
        clear_flags();
        drain("mti_pend");
        chk("mti_pend_cause", last_cause, 32'h80000007);

        // mret.
        mstatus = 32'h1880; mepc = 32'h104; valid = 1; mret = 1;
        step(); chk("mret_flush", obs_flush, 1);
        clear_flags();
        expect_w("mret_mstatus", 12'h300, 32'h1888);
        expect_redir("mret", 32'h104);
        step(); chk("mret_after_busy", obs_busy, 0);

        // WB write of mstatus forwarded into the trap in the same cycle.
        mstatus = 32'h0; mtvec = 32'h200; pc = 32'h180; valid = 1; ecall = 1;
        wb_we = 1; wb_waddr = 12'h300; wb_wdata = 32'h8;
        step();
        chk("fwd_flush", obs_flush, 1); chk("fwd_we", obs_we, 1);
        chk("fwd_addr", obs_addr, 12'h300); chk("fwd_data", obs_data, 32'h8);
        clear_flags();
        expect_w("fwd_mepc", 12'h341, 32'h180);
        expect_w("fwd_mcause", 12'h342, 32'd11);
        expect_w("fwd_mstatus", 12'h300, 32'h1880);
        expect_redir("fwd", 32'h200);
        step();

        // Reset two cycles into a trap sequence.
        mstatus = 32'h8; pc = 32'h500; valid = 1; ecall = 1;
        step(); chk("rst_seq_flush", obs_flush, 1);
        clear_flags();
        expect_w("rst_seq_mepc", 12'h341, 32'h500);
        rst_n = 0;
        #1;
        chk("rst_imm_we", bus.csr_we_o, 0); chk("rst_imm_busy", busy, 0);
        chk("rst_imm_flush", flush, 0); chk("rst_imm_redir", redirect, 0);
        chk("rst_imm_rpc", redirect_pc, 0);
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rst_after%0d_we", k), obs_we, 0);
            chk($sformatf("rst_after%0d_busy", k), obs_busy, 0);
        end
        wb_we = 1; wb_waddr = 12'h342; wb_wdata = 32'hABCD;
        step();
        chk("rst_pass_we", obs_we, 1); chk("rst_pass_addr", obs_addr, 12'h342);
        chk("rst_pass_data", obs_data, 32'hABCD);
        wb_we = 0;
        step();

        // Randomized run against the model; WB stays quiet while the sequencer is busy.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] sel;
            valid   = ($urandom_range(0, 1) == 1);
            illegal = ($urandom_range(0, 9) == 0);
            ebreak  = ($urandom_range(0, 9) == 0);
            ecall   = ($urandom_range(0, 9) == 0);
            mret    = ($urandom_range(0, 7) == 0);
            meip    = ($urandom_range(0, 3) == 0);
            mtip    = ($urandom_range(0, 3) == 0);
            msip    = ($urandom_range(0, 3) == 0);
            pc      = $urandom;
            mstatus = $urandom;
            mie     = $urandom;
            mtvec   = $urandom;
            mepc    = $urandom;
            sel     = 3'($urandom_range(0, 4));
            wb_waddr = (sel == 0) ? 12'h300 : (sel == 1) ? 12'h305 : (sel == 2) ? 12'h341 :
                       (sel == 3) ? 12'h342 : 12'($urandom);
            wb_wdata = $urandom;
            wb_we    = (q.size() == 0) && ($urandom_range(0, 2) == 0);
            step();
        end
        clear_flags();
        drain("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
